operand_read: RTL

- Register-file read side and operand-dispatch stage. Takes decoded instructions from decode.
- Reads rs1/rs2 from the register file's `full_table` snapshot and forwards same-cycle writeback data.
- Tracks in-flight destination registers in a scoreboard and stalls on RAW hazards.
- Hands operands to execute through a one-entry output register with valid/ready handshake.

---
 rtl/registers_types.sv | 42 ++++
 rtl/reg_scoreboard.sv | 60 ++++++
 rtl/operand_read.sv | 113 +++++++++++
 3 files changed

// File: rtl/registers_types.sv
// Shared register-file types plus the operand request/response records used by operand_read.
// Holds the bypass-aware operand selector so every reader picks sources the same way.
package registers_types;

  typedef logic [63:0] double_word;
  typedef logic [4:0]  reg_idx_t;

  typedef struct packed {
    double_word [31:0] x_regs;
    double_word        pc;
  } register_holder_t;

  typedef struct packed {
    reg_idx_t   rs1;
    reg_idx_t   rs2;
    reg_idx_t   rd;
    logic       rd_write;
    double_word pc;
  } operand_req_t;

  typedef struct packed {
    double_word rs1_value;
    double_word rs2_value;
    reg_idx_t   rd;
    logic       rd_write;
    double_word pc;
  } operand_resp_t;

  // x0 reads as zero; a same-cycle writeback wins over the register file snapshot.
  function automatic double_word select_operand(
    input reg_idx_t         src,
    input logic             wb_en,
    input reg_idx_t         wb_entry,
    input double_word       wb_value,
    input register_holder_t rf
  );
    if (src == '0)                        return '0;
    else if (wb_en && (wb_entry == src)) return wb_value;
    else                                  return rf.x_regs[src];
  endfunction

endpackage

// File: rtl/reg_scoreboard.sv
// Per-register count of dispatched-but-not-written-back writes (x0 never tracked).
// Same-cycle inc/dec on one index cancel; a decrement at zero holds at zero.
module reg_scoreboard
  import registers_types::*;
#(
  parameter int PEND_W = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        inc_en,
  input  reg_idx_t    inc_idx,
  input  logic        dec_en,
  input  reg_idx_t    dec_idx,
  output logic [31:0] pending_nz,
  output logic [31:0] pending_multi,
  output logic [31:0] saturated,
  output logic [31:0] near_sat
);

  localparam logic [PEND_W-1:0] CNT_MAX = '1;
  localparam logic [PEND_W-1:0] CNT_ONE = PEND_W'(1);

  logic [PEND_W-1:0] cnt [32];
  logic [31:0]       inc_hit;
  logic [31:0]       dec_hit;
  logic              dec_underflow;

  always_comb begin
    inc_hit       = (inc_en && (inc_idx != '0)) ? (32'd1 << inc_idx) : 32'd0;
    dec_hit       = (dec_en && (dec_idx != '0)) ? (32'd1 << dec_idx) : 32'd0;
    pending_nz    = '0;
    pending_multi = '0;
    saturated     = '0;
    near_sat      = '0;
    dec_underflow = 1'b0;
    for (int i = 0; i < 32; i++) begin
      pending_nz[i]    = (cnt[i] != '0);
      pending_multi[i] = (cnt[i] > CNT_ONE);
      saturated[i]     = (cnt[i] == CNT_MAX);
      near_sat[i]      = (cnt[i] == (CNT_MAX - CNT_ONE));
      dec_underflow    = dec_underflow | (dec_hit[i] & ~inc_hit[i] & (cnt[i] == '0));
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < 32; i++) begin
      if (rst || (i == 0)) begin
        cnt[i] <= '0;
      end else if (inc_hit[i] && !dec_hit[i]) begin
        cnt[i] <= cnt[i] + CNT_ONE;
      end else if (dec_hit[i] && !inc_hit[i] && (cnt[i] != '0)) begin
        cnt[i] <= cnt[i] - CNT_ONE;
      end
    end
  end

  // A writeback with no matching outstanding write means the pipeline lost track of a writer.
  assert property (@(posedge clk) disable iff (rst) !dec_underflow);

endmodule

// File: rtl/operand_read.sv
// Operand read/dispatch: bypassed register reads, RAW/saturation stalls, one-entry output register.
// Accept-to-out_valid is 1 cycle; execute backpressure (out_ready=0) holds out_* and drops in_ready.
module operand_read
  import registers_types::*;
#(
  parameter int PEND_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  register_holder_t full_table,
  input  logic             in_valid,
  output logic             in_ready,
  input  reg_idx_t         in_rs1,
  input  reg_idx_t         in_rs2,
  input  reg_idx_t         in_rd,
  input  logic             in_rd_write,
  input  double_word       in_pc,
  output logic             out_valid,
  input  logic             out_ready,
  output double_word       out_rs1_value,
  output double_word       out_rs2_value,
  output reg_idx_t         out_rd,
  output logic             out_rd_write,
  output double_word       out_pc,
  input  logic             wb_en,
  input  reg_idx_t         wb_entry,
  input  double_word       wb_value,
  input  logic             flush
);

  operand_req_t  req;
  operand_resp_t resp_d;
  operand_resp_t out_q;
  logic          out_vld_q;

  logic [31:0] pend_nz;
  logic [31:0] pend_multi;
  logic [31:0] pend_sat;
  logic [31:0] pend_near;

  logic wbm_rs1, wbm_rs2, wbm_rd, out_hit_rd;
  logic haz_rs1, haz_rs2, sat_stall;
  logic accept, dispatch, inc_en;
  logic unused_pc;

  assign req = '{rs1: in_rs1, rs2: in_rs2, rd: in_rd, rd_write: in_rd_write, pc: in_pc};
  assign unused_pc = ^full_table.pc;

  always_comb begin
    wbm_rs1    = wb_en && (wb_entry == req.rs1);
    wbm_rs2    = wb_en && (wb_entry == req.rs2);
    wbm_rd     = wb_en && (wb_entry == req.rd);
    out_hit_rd = out_vld_q && out_q.rd_write && (out_q.rd == req.rd);

    // An outstanding writer in the output register stalls readers even in its dispatch cycle.
    haz_rs1 = (req.rs1 != '0) &&
              ((out_vld_q && out_q.rd_write && (out_q.rd == req.rs1)) ||
               (pend_nz[req.rs1] && !(wbm_rs1 && !pend_multi[req.rs1])));
    haz_rs2 = (req.rs2 != '0) &&
              ((out_vld_q && out_q.rd_write && (out_q.rd == req.rs2)) ||
               (pend_nz[req.rs2] && !(wbm_rs2 && !pend_multi[req.rs2])));

    // The writer sitting in the output register will also count once it dispatches,
    // so it is included here to keep the counter from wrapping.
    sat_stall = req.rd_write && (req.rd != '0) &&
                ((pend_sat[req.rd] && !wbm_rd) ||
                 (out_hit_rd && (pend_sat[req.rd] || (pend_near[req.rd] && !wbm_rd))));

    in_ready = (!out_vld_q || out_ready) && !haz_rs1 && !haz_rs2 && !sat_stall && !flush;
    accept   = in_valid && in_ready;
    dispatch = out_vld_q && out_ready && !flush;
    inc_en   = dispatch && out_q.rd_write && (out_q.rd != '0);

    resp_d.rs1_value = select_operand(req.rs1, wb_en, wb_entry, wb_value, full_table);
    resp_d.rs2_value = select_operand(req.rs2, wb_en, wb_entry, wb_value, full_table);
    resp_d.rd        = req.rd;
    resp_d.rd_write  = req.rd_write;
    resp_d.pc        = req.pc;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_vld_q <= 1'b0;
      out_q     <= '0;
    end else if (accept) begin
      out_vld_q <= 1'b1;
      out_q     <= resp_d;
    end else if (flush || dispatch) begin
      out_vld_q <= 1'b0;
    end
  end

  reg_scoreboard #(.PEND_W(PEND_W)) u_sb (
    .clk           (clk),
    .rst           (rst),
    .inc_en        (inc_en),
    .inc_idx       (out_q.rd),
    .dec_en        (wb_en),
    .dec_idx       (wb_entry),
    .pending_nz    (pend_nz),
    .pending_multi (pend_multi),
    .saturated     (pend_sat),
    .near_sat      (pend_near)
  );

  assign out_valid     = out_vld_q;
  assign out_rs1_value = out_q.rs1_value;
  assign out_rs2_value = out_q.rs2_value;
  assign out_rd        = out_q.rd;
  assign out_rd_write  = out_q.rd_write;
  assign out_pc        = out_q.pc;

endmodule
